// File: rtl/sd_dac_pkg.sv
// rtl/sd_dac_pkg.sv - shared types, sizing and density helper for the sigma-delta DAC
package sd_dac_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRIME = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   localparam int DEF_OSR = 64;
   localparam int CNT_W   = $clog2(DEF_OSR);

   function automatic int cnt_w(input int osr);
      return (osr <= 2) ? 1 : $clog2(osr);
   endfunction

   // Ones emitted after n cycles of constant word c, starting from accumulator acc0.
   function automatic int unsigned exp_ones(input int unsigned acc0, input int unsigned c,
                                            input int unsigned n, input int unsigned width);
      return (acc0 + c * n) >> width;
   endfunction

endpackage

// File: rtl/sd_dac_mod.sv
// rtl/sd_dac_mod.sv - first-order error accumulator and registered bitstream output
module sd_dac_mod
   import sd_dac_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic [WIDTH-1:0] cur,
   output logic             bit_out
);

   logic [WIDTH-1:0] acc;
   logic [WIDTH:0]   sum;

   assign sum = {1'b0, acc} + {1'b0, cur};

   // The carry out is the output bit; the remainder is kept so error carries across periods.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc     <= '0;
         bit_out <= 1'b0;
      end else if (clr) begin
         acc     <= '0;
         bit_out <= 1'b0;
      end else if (en) begin
         acc     <= sum[WIDTH-1:0];
         bit_out <= sum[WIDTH];
      end
   end

endmodule

// File: rtl/sd_dac.sv
// rtl/sd_dac.sv - sigma-delta DAC top: handshake, look-ahead buffer, period counter, FSM
module sd_dac
   import sd_dac_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int OSR   = DEF_OSR
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             bit_out,
   output logic             sample_tick,
   output logic             underrun,
   output logic             busy
);

   localparam int CW = cnt_w(OSR);

   state_t           state, state_nx;
   logic [WIDTH-1:0] cur, pend;
   logic             pend_full;
   logic [CW-1:0]    cnt;
   logic             accept;

   assign sample_tick = (state == ST_RUN) && (cnt == CW'(OSR - 1));
   assign din_ready   = enable && (state != ST_IDLE) && (!pend_full || sample_tick);
   assign accept      = din_valid && din_ready;
   assign underrun    = sample_tick && !pend_full && !accept;
   assign busy        = (state == ST_RUN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (!enable) begin
         state_nx = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:  state_nx = ST_PRIME;
            ST_PRIME: if (accept) state_nx = ST_RUN;
            ST_RUN:   state_nx = ST_RUN;
            default:  state_nx = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur       <= '0;
         pend      <= '0;
         pend_full <= 1'b0;
         cnt       <= '0;
      end else if (!enable) begin
         cur       <= '0;
         pend      <= '0;
         pend_full <= 1'b0;
         cnt       <= '0;
      end else begin
         case (state)
            ST_PRIME: begin
               if (accept) begin
                  cur <= din;
                  cnt <= '0;
               end
            end
            ST_RUN: begin
               cnt <= sample_tick ? '0 : cnt + CW'(1);
               // Period end: promote the buffered word, or take a same-cycle word straight in.
               if (sample_tick) begin
                  if (pend_full) begin
                     cur <= pend;
                     if (accept) pend <= din;
                     else        pend_full <= 1'b0;
                  end else if (accept) begin
                     cur <= din;
                  end
               end else if (accept) begin
                  pend      <= din;
                  pend_full <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   sd_dac_mod #(.WIDTH(WIDTH)) u_mod (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (!enable || (state != ST_RUN)),
      .en      (state == ST_RUN),
      .cur     (cur),
      .bit_out (bit_out)
   );

endmodule

// File: tb/tb_sd_dac.sv
// tb/tb_sd_dac.sv - directed self-checking bench for sd_dac
module tb_sd_dac;
   import sd_dac_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic [7:0] din;
   logic       din_valid;
   logic       din_ready, bit_out, sample_tick, underrun, busy;

   int checks   = 0;
   int failures = 0;

   int ones, ticks, unders, readies, tick_at;
   logic [7:0] first8;

   sd_dac #(.WIDTH(8), .OSR(64)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .din         (din),
      .din_valid   (din_valid),
      .din_ready   (din_ready),
      .bit_out     (bit_out),
      .sample_tick (sample_tick),
      .underrun    (underrun),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      ones = 0; ticks = 0; unders = 0; readies = 0; tick_at = -1; first8 = '0;
      for (int i = 0; i < n; i++) begin
         if (sample_tick) begin ticks++; tick_at = i; end
         if (underrun)  unders++;
         if (din_ready) readies++;
         step();
         if (bit_out) ones++;
         if (i < 8) first8[i] = bit_out;
      end
   endtask

   task automatic restart();
      enable = 1'b0;
      din_valid = 1'b0;
      step();
      chk("restart_busy", busy, 0);
      enable = 1'b1;
      step();
   endtask

   task automatic load(input logic [7:0] w);
      din = w;
      din_valid = 1'b1;
      #1;
      chk("prime_ready", din_ready, 1);
      step();
      chk("load_busy", busy, 1);
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b0; din = '0; din_valid = 1'b0;
      #12;
      chk("rst_bit_out", bit_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", din_ready, 0);
      chk("rst_tick", sample_tick, 0);
      chk("rst_underrun", underrun, 0);
      @(negedge clk);
      rst_n = 1'b1; enable = 1'b1;
      #1;
      chk("idle_ready", din_ready, 0);
      step();
      chk("prime_ready_after_idle", din_ready, 1);
      chk("prime_busy", busy, 0);

      // 0x80: alternating bitstream, 32 ones per period
      load(8'h80);
      din_valid = 1'b0;
      run(64);
      chk("a_first8", first8, 8'b1010_1010);
      chk("a_ones", ones, 32);
      chk("a_ticks", ticks, 1);
      chk("a_tick_at", tick_at, 63);

      // 0x40 then 0xC0 streamed with valid held high
      restart();
      load(8'h40);
      din = 8'hC0;
      run(64);
      chk("b1_ones", ones, 16);
      chk("b1_readies", readies, 2);
      chk("b1_underrun", unders, 0);
      run(64);
      chk("b2_ones", ones, 48);
      chk("b2_readies", readies, 1);
      chk("b2_underrun", unders, 0);
      din_valid = 1'b0;

      // 0x00 then 0xFF
      restart();
      load(8'h00);
      din = 8'hFF;
      #1;
      chk("c_ready_pend_empty", din_ready, 1);
      step();
      chk("c_bit0", bit_out, 0);
      din_valid = 1'b0;
      #1;
      chk("c_ready_pend_full", din_ready, 0);
      run(63);
      chk("c1_ones", ones, 0);
      chk("c1_tick_at", tick_at, 62);
      chk("c1_underrun", unders, 0);
      run(256);
      chk("c2_ones", ones, int'(exp_ones(0, 255, 256, 8)));
      chk("c2_ones_const", ones, 255);

      // single 0x20, then starvation
      restart();
      load(8'h20);
      din_valid = 1'b0;
      run(64);
      chk("d1_ones", ones, 8);
      chk("d1_underrun", unders, 1);
      chk("d1_tick_at", tick_at, 63);
      run(64);
      chk("d2_ones", ones, int'(exp_ones(0, 32, 128, 8)) - 8);
      chk("d2_underrun", unders, 1);

      // enable drop with a word pending mid-period
      restart();
      load(8'h40);
      din = 8'hC0;
      step();
      din_valid = 1'b0;
      run(10);
      chk("e_ready_full", din_ready, 0);
      enable = 1'b0;
      step();
      chk("e_busy", busy, 0);
      chk("e_bit_out", bit_out, 0);
      chk("e_ready", din_ready, 0);
      chk("e_tick", sample_tick, 0);
      enable = 1'b1;
      step();
      chk("e_prime_ready", din_ready, 1);
      chk("e_prime_busy", busy, 0);
      load(8'h80);
      din_valid = 1'b0;
      run(64);
      chk("e_ones", ones, 32);
      chk("e_underrun_pend_empty", unders, 1);

      // asynchronous reset mid-RUN
      restart();
      load(8'hFF);
      din_valid = 1'b0;
      run(5);
      chk("f_bit_pre", bit_out, 1);
      chk("f_ones_pre", ones, 4);
      #2;
      rst_n = 1'b0;
      #1;
      chk("f_rst_bit_out", bit_out, 0);
      chk("f_rst_busy", busy, 0);
      chk("f_rst_ready", din_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("f_ready_after", din_ready, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
